// File: rtl/acc_mch.sv
// acc_mch - multi-channel streaming accumulator.
//
// Keeps NCH independent signed running sums. Each input beat is routed to a
// channel by in_ch. A beat tagged in_last pushes that channel's final sum into a
// single-entry output register and restarts the channel.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   clr                   synchronous clear of all sums and overflow flags
//   in_valid/in_ready     input handshake; in_ch, in_data, in_last are the beat
//   out_valid/out_ready   output handshake; out_ch, out_data, out_ovf are the result
//   rd_ch/rd_data         combinational peek of a running sum (0 if rd_ch >= NCH)
//
// Build option: define ACC_MCH_SAT_EN to saturate on overflow instead of
// wrapping. Overflow flags behave the same in both builds.

module acc_mch #(
    parameter int DW  = 8,
    parameter int AW  = 16,
    parameter int NCH = 4,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_ch,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_ch,
    output logic [AW-1:0]        out_data,
    output logic                 out_ovf,
    input  logic [CW-1:0]        rd_ch,
    output logic [AW-1:0]        rd_data
);

    // NCH always fits in CW+1 bits, so this compare never truncates.
    localparam logic [CW:0] NCH_W = NCH[CW:0];

    logic [NCH-1:0][AW-1:0] acc;
    logic [NCH-1:0]         ovf;

    logic          accept;
    logic          ch_ok;
    logic [AW-1:0] cur_acc;
    logic          cur_ovf;
    logic [AW:0]   sum;
    logic          sum_ovf;
    logic [AW-1:0] stored;

    // Output held -> stall everything, including non-last beats. clr also
    // blocks input so the cleared cycle cannot merge or lose a beat.
    assign in_ready = (!out_valid || out_ready) && !clr;
    assign accept   = in_valid && in_ready;
    assign ch_ok    = {1'b0, in_ch} < NCH_W;

    // Select the addressed channel without indexing past NCH.
    always_comb begin
        cur_acc = '0;
        cur_ovf = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (in_ch == CW'(i)) begin
                cur_acc = acc[i];
                cur_ovf = ovf[i];
            end
        end
    end

    // One guard bit: the sum overflows AW bits iff the top two bits differ.
    assign sum     = {cur_acc[AW-1], cur_acc} + {{(AW+1-DW){in_data[DW-1]}}, in_data};
    assign sum_ovf = sum[AW] ^ sum[AW-1];

`ifdef ACC_MCH_SAT_EN
    // sum[AW] is the sign of the true sum.
    always_comb begin
        stored = sum[AW-1:0];
        if (sum_ovf)
            stored = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
`else
    assign stored = sum[AW-1:0];
`endif

    // Per-channel accumulator state.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic hit;
        assign hit = accept && ch_ok && (in_ch == CW'(g));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc[g] <= '0;
                ovf[g] <= 1'b0;
            end else if (clr) begin
                acc[g] <= '0;
                ovf[g] <= 1'b0;
            end else if (hit) begin
                if (in_last) begin
                    acc[g] <= '0;
                    ovf[g] <= 1'b0;
                end else begin
                    acc[g] <= stored;
                    ovf[g] <= ovf[g] | sum_ovf;
                end
            end
        end
    end

    // Single-entry result register; a last beat in the drain cycle refills it
    // directly, giving full throughput. clr leaves a pending result alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (accept && ch_ok && in_last) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= stored;
            out_ovf   <= cur_ovf | sum_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CW'(i)) rd_data = acc[i];
        end
    end

endmodule

// File: tb/tb_acc_mch.sv
// Directed testbench for acc_mch (DW=8, AW=12, NCH=3).
module tb_acc_mch;

    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int NCH = 3;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ch;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ch;
    logic [AW-1:0] out_data;
    logic          out_ovf;
    logic [CW-1:0] rd_ch;
    logic [AW-1:0] rd_data;

    int total  = 0;
    int passed = 0;

    acc_mch #(.DW(DW), .AW(AW), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_data(out_data), .out_ovf(out_ovf),
        .rd_ch(rd_ch), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present one beat and let the next rising edge take it.
    task automatic beat(input int ch, input int d, input bit last);
        in_valid = 1'b1;
        in_ch    = CW'(ch);
        in_data  = DW'(d);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic peek(input string tag, input int ch, input int exp);
        rd_ch = CW'(ch);
        #1;
        chk(tag, $signed(rd_data), exp);
    endtask

    task automatic chk_out(input string tag, input int ch, input int d, input int o);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_ch"}, out_ch, ch);
        chk({tag, "_data"}, $signed(out_data), d);
        chk({tag, "_ovf"}, out_ovf, o);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b1; rd_ch = '0;
        #9;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", $signed(out_data), 0);
        for (int c = 0; c < NCH; c++) peek("rst_rd", c, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single frame on ch1.
        beat(1, 10, 0);
        beat(1, -3, 0);
        peek("f1_partial", 1, 7);
        beat(1, 5, 1);
        chk_out("f1", 1, 12, 0);
        peek("f1_restart", 1, 0);
        idle();
        chk("f1_drained", out_valid, 0);

        // Interleaved channels.
        beat(0, 1, 0);
        beat(2, 7, 0);
        beat(0, 2, 0);
        beat(2, -1, 1);
        chk_out("il_a", 2, 6, 0);
        beat(0, 3, 1);
        chk_out("il_b", 0, 6, 0);
        idle();

        // Backpressure: held result stalls all input.
        out_ready = 1'b0;
        beat(0, 4, 1);
        chk_out("bp", 0, 4, 0);
        in_valid = 1'b1; in_ch = 2'd1; in_data = 8'd99; in_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", $signed(out_data), 4);
        end
        in_valid = 1'b0;
        peek("bp_no_accept", 1, 0);
        // Drain and refill at the same edge.
        out_ready = 1'b1;
        in_valid = 1'b1; in_ch = 2'd2; in_data = 8'd8; in_last = 1'b1;
        #1;
        chk("bp_drain_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk_out("bp_refill", 2, 8, 0);
        idle();
        chk("bp_empty", out_valid, 0);
        chk("bp_ready_after", in_ready, 1);

        // Overflow on ch1: 17 x 127 = 2159.
        for (int k = 0; k < 16; k++) beat(1, 127, 0);
        beat(1, 127, 1);
`ifdef ACC_MCH_SAT_EN
        chk_out("ovf", 1, 2047, 1);
`else
        chk_out("ovf", 1, -1937, 1);
`endif
        idle();
        beat(1, 1, 1);
        chk_out("ovf_next", 1, 1, 0);
        idle();

        // clr with a beat offered.
        beat(0, 50, 0);
        peek("clr_pre", 0, 50);
        clr = 1'b1; in_valid = 1'b1; in_ch = 2'd0; in_data = 8'd5;
        #1;
        chk("clr_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        peek("clr_post", 0, 0);

        // Out-of-range channel is swallowed.
        beat(2, 3, 0);
        in_valid = 1'b1; in_ch = 2'd3; in_data = 8'd9; in_last = 1'b1;
        #1;
        chk("bad_ch_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("bad_ch_no_out", out_valid, 0);
        peek("bad_ch_ch0", 0, 0);
        peek("bad_ch_ch1", 1, 0);
        peek("bad_ch_ch2", 2, 3);
        peek("bad_rd_ch", 3, 0);

        // Async reset mid-frame with a pending result.
        beat(2, 17, 0);
        out_ready = 1'b0;
        beat(0, 1, 1);
        chk("ar_pending", out_valid, 1);
        peek("ar_pre", 2, 20);
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        peek("ar_rd", 2, 0);
        rst_n = 1'b1;
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/acc_mch.md
Name: acc_mch

Overview:
- Multi-channel streaming accumulator; successor to the single-channel register accumulator.
- Keeps NCH independent signed running sums, selected per beat by a channel index, on a valid/ready input stream.
- A beat tagged last emits the final channel sum on a valid/ready output stream and restarts that channel.
- Sits between sample producers (filters, counters) and result consumers (DMA, CSR readback).

Parameters:
- DW, 8, input sample width (signed two's complement)
- AW, 16, accumulator/result width (signed); must be >= DW
- NCH, 4, number of channels; >= 1, need not be a power of 2
- CW, $clog2(NCH) (min 1), channel index width; derived, do not override

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of all channel sums and overflow flags
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat ready
- in_ch  in  CW  target channel of beat
- in_data  in  DW  signed sample
- in_last  in  1  final beat of this channel's frame
- out_valid  out  1  result valid
- out_ready  in  1  result ready
- out_ch  out  CW  channel of result
- out_data  out  AW  final signed sum
- out_ovf  out  1  overflow occurred during this frame
- rd_ch  in  CW  peek channel select
- rd_data  out  AW  combinational peek of acc[rd_ch]; 0 if rd_ch >= NCH

Behaviour:
- Reset: all acc[i]=0, ovf[i]=0, out_valid=0, out_ch=0, out_data=0, out_ovf=0.
- in_ready = (!out_valid || out_ready) && !clr. Accept = in_valid && in_ready.
- Sum computation:
  - sum = acc[in_ch] + sign_extend(in_data), computed in AW+1 bits.
  - Signed overflow = sum does not fit in AW bits.
  - Stored value per the Optional Feature.
- Non-last accept: acc[in_ch] <= stored value and ovf[in_ch] <= ovf[in_ch] | overflow, at next edge; latency 1.
- Last accept, all at the same edge:
  - out_data <= stored value, out_ch <= in_ch, out_ovf <= ovf[in_ch] | overflow, out_valid <= 1.
  - acc[in_ch] <= 0 and ovf[in_ch] <= 0.
- Output register:
  - Single entry; cleared when out_valid && out_ready, unless refilled by a last accept at the same edge.
  - Back-to-back last beats at full throughput when out_ready=1.
  - out_* stable while out_valid && !out_ready.
- Stall: when the output is held, all input is stalled (in_ready=0), including non-last beats.
- clr:
  - Zeroes every acc[i] and ovf[i] at the next edge; in_ready=0 that cycle, so no beat is lost or merged.
  - A pending output is unaffected.
- in_ch >= NCH: beat accepted and discarded; no state change, no output, even if in_last.
- Mid-operation reset: all state and any pending output are dropped immediately.
- Channels are independent; interleaving arbitrary in_ch sequences is legal.

Optional Feature:
- Macro ACC_MCH_SAT_EN.
- Defined: on overflow the stored value saturates to +2^(AW-1)-1 or -2^(AW-1), per the sign of the true sum.
- Undefined: the stored value wraps (low AW bits of sum).
- out_ovf and the ovf flags behave identically in both builds.

Test Plan (DW=8, AW=12, NCH=3, CW=2):
- Reset and single frame:
  - Reset: out_valid=0, rd_data=0 for all ch.
  - Then ch1 beats 10, -3, 5(last), out_ready=1.
  - Result: out_valid one cycle after last; out_ch=1, out_data=12, out_ovf=0; rd_data(ch1)=0 afterwards.
- Interleaved channels:
  - Beats ch0:+1, ch2:+7, ch0:+2, ch2:-1(last), ch0:+3(last).
  - Outputs in order: (ch2,6,0) then (ch0,6,0).
- Backpressure:
  - out_ready=0, ch0 last beat 4 -> out_valid=1 held, in_ready=0, out_data stable at 4 for 5 cycles.
  - out_ready=1 -> transfer; in_ready=1 next cycle.
  - A last beat in the drain cycle yields a new result with no bubble.
- Overflow:
  - ch1: 17 beats of +127, last on 17th (true sum 2159).
  - Saturating build: out_data=2047, out_ovf=1. Wrapping build: out_data=-1937, out_ovf=1.
  - Next ch1 frame of +1(last): out_data=1, out_ovf=0.
- clr and invalid channel:
  - ch0 accumulates 50; clr pulses with in_valid=1 -> in_ready=0 that cycle, rd_data(ch0)=0 next cycle.
  - Then in_ch=3, data 9, last -> accepted, no output, all sums unchanged.
- Async reset mid-frame:
  - rst_n low while out_valid=1 and ch2 sum=20 -> out_valid=0, rd_data(ch2)=0 immediately, with no clock edge required.
